byte_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 20 ++
 rtl/byte_serializer.sv | 115 +++++++++++
 tb/tb_byte_serializer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial front end and the
// detector-side blocks.
package serial_pkg;

  localparam int SER_WIDTH = 8;

  localparam logic SER_IDLE_BIT = 1'b1;

  localparam int SER_CNT_W = $clog2(SER_WIDTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Word-to-bit serializer with a one-entry skid so consecutive
// words leave back to back on x_out.
module byte_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = SER_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  ser_state_t state, state_n;

  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [WIDTH-1:0] sh_adv;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             accept;
  logic             active;

  assign active = (state == S_SHIFT);
  assign accept = in_valid && !hold_full;

  // Advance the shifter one position toward the output end.
  always_comb begin
    sh_adv = sh;
    if (MSB_FIRST) begin
      sh_adv = {sh[WIDTH-2:0], 1'b0};
    end else begin
      sh_adv = {1'b0, sh[WIDTH-1:1]};
    end
  end

  // Next-state logic for shifter, counter and skid entry.
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          sh_n    = in_data;
          cnt_n   = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt != LAST) begin
          sh_n  = sh_adv;
          cnt_n = cnt + ONE;
          if (accept) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          sh_n        = hold;
          hold_full_n = 1'b0;
          cnt_n       = '0;
        end else if (accept) begin
          sh_n  = in_data;
          cnt_n = '0;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State registers; reset drops any word in flight or held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    x_out = IDLE_BIT;
    if (active) begin
      x_out = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    end
    bit_valid  = active;
    frame_last = active && (cnt == LAST);
    in_ready   = !hold_full;
    busy       = active || hold_full;
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed checks for byte_serializer, MSB-first and
// LSB-first builds driven from the same source.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic in_ready, x_out, bit_valid;
  logic frame_last, busy;
  logic l_ready, l_x, l_bv, l_last, l_busy;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  byte_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)
  ) u_msb (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x_out(x_out),
    .bit_valid(bit_valid), .frame_last(frame_last),
    .busy(busy)
  );

  byte_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)
  ) u_lsb (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .x_out(l_x),
    .bit_valid(l_bv), .frame_last(l_last),
    .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    reset = 1'b0;
    #2;
    obs = {x_out, in_ready, bit_valid, busy};
    total++;
    if (obs !== 4'b1100)
      $display("FAIL reset_state got %b want 1100", obs);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      obs = {x_out, in_ready, bit_valid, busy};
      total++;
      if (obs !== 4'b1100)
        $display("FAIL idle_%0d got %b want 1100", i, obs);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_w;
    logic [3:0] win;
    int hits;
    exp_w = 8'b0110_0110;
    win = 4'b1111;
    hits = 0;
    in_data = 8'h66;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (x_out !== exp_w[7-i] || bit_valid !== 1'b1)
        $display("FAIL single_bit%0d got x=%b v=%b want x=%b v=1",
                 i, x_out, bit_valid, exp_w[7-i]);
      else pass_cnt++;
      total++;
      if (frame_last !== (i == 7))
        $display("FAIL single_last%0d got %b want %b",
                 i, frame_last, (i == 7));
      else pass_cnt++;
      if (bit_valid) begin
        win = {win[2:0], x_out};
        if (win == 4'b0110) hits++;
      end
      tick();
    end
    total++;
    if (bit_valid !== 1'b0 || busy !== 1'b0 || x_out !== 1'b1)
      $display("FAIL single_end got v=%b b=%b x=%b want 0 0 1",
               bit_valid, busy, x_out);
    else pass_cnt++;
    total++;
    if (hits != 2)
      $display("FAIL detect_0110 got %0d want 2", hits);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s;
    logic        exp_r;
    exp_s = 16'b1010_0101_0011_1100;
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      exp_r = !(i >= 1 && i <= 7);
      total++;
      if (x_out !== exp_s[15-i] || bit_valid !== 1'b1)
        $display("FAIL b2b_bit%0d got x=%b v=%b want x=%b v=1",
                 i, x_out, bit_valid, exp_s[15-i]);
      else pass_cnt++;
      total++;
      if (in_ready !== exp_r)
        $display("FAIL b2b_ready%0d got %b want %b",
                 i, in_ready, exp_r);
      else pass_cnt++;
      if (i == 1) in_valid = 1'b0;
      tick();
    end
    total++;
    if (bit_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_end got v=%b b=%b want 0 0",
               bit_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [15:0] exp_s;
    exp_s = 16'hF00F;
    in_data = 8'hF0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        in_data = 8'h0F;
        in_valid = 1'b1;
      end
      if (i == 8) in_valid = 1'b0;
      total++;
      if (x_out !== exp_s[15-i] || bit_valid !== 1'b1)
        $display("FAIL byp_bit%0d got x=%b v=%b want x=%b v=1",
                 i, x_out, bit_valid, exp_s[15-i]);
      else pass_cnt++;
      total++;
      if (in_ready !== 1'b1 ||
          frame_last !== (i == 7 || i == 15))
        $display("FAIL byp_ctl%0d got r=%b l=%b want r=1 l=%b",
                 i, in_ready, frame_last, (i == 7 || i == 15));
      else pass_cnt++;
      tick();
    end
    total++;
    if (bit_valid !== 1'b0)
      $display("FAIL byp_end got v=%b want 0", bit_valid);
    else pass_cnt++;
  endtask

  task automatic test_lsb();
    logic [7:0] exp_w;
    exp_w = 8'b1000_0000;
    in_data = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (l_x !== exp_w[7-i] || l_bv !== 1'b1)
        $display("FAIL lsb_bit%0d got x=%b v=%b want x=%b v=1",
                 i, l_x, l_bv, exp_w[7-i]);
      else pass_cnt++;
      total++;
      if (l_last !== (i == 7))
        $display("FAIL lsb_last%0d got %b want %b",
                 i, l_last, (i == 7));
      else pass_cnt++;
      tick();
    end
    total++;
    if (l_bv !== 1'b0 || l_busy !== 1'b0 || l_x !== 1'b1)
      $display("FAIL lsb_end got v=%b b=%b x=%b want 0 0 1",
               l_bv, l_busy, l_x);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL mid_pre got b=%b r=%b want 1 0",
               busy, in_ready);
    else pass_cnt++;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (x_out !== 1'b1 || busy !== 1'b0 ||
        bit_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_rst got x=%b b=%b v=%b r=%b want 1 0 0 1",
               x_out, busy, bit_valid, in_ready);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (bit_valid !== 1'b0 || x_out !== 1'b1 || busy !== 1'b0)
        $display("FAIL mid_after%0d got v=%b x=%b b=%b want 0 1 0",
                 i, bit_valid, x_out, busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_bypass();
    tick();
    test_lsb();
    tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
